poly_voice_stack: RTL

Polyphonic voice allocator and square-wave oscillator stack. It sits between the MIDI decoder's note/strobe outputs and the synth top's `oscOut_o`/`activeOscPwm_o` pins, replacing the tied-off outputs. Each note-on is mapped to one of `VOICES` oscillators, and each note-off releases it. When all voices are busy, the block either ignores the new note or steals the oldest voice, selected at elaboration.

---
 rtl/poly_voice_stack_if.sv | 22 ++
 rtl/poly_voice_stack.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/poly_voice_stack_if.sv
// Note/strobe bus from the MIDI decoder into the voice stack, plus the
// oscillator, busy and PWM outputs back out to the synth top pins.
interface poly_voice_stack_if #(
  parameter int VOICES = 4
);
  logic [6:0]        note_i;
  logic              noteOnStrb_i;
  logic              noteOffStrb_i;
  logic [VOICES-1:0] oscOut_o;
  logic [VOICES-1:0] voiceActive_o;
  logic              activeOscPwm_o;

  modport master (
    output note_i, noteOnStrb_i, noteOffStrb_i,
    input  oscOut_o, voiceActive_o, activeOscPwm_o
  );

  modport slave (
    input  note_i, noteOnStrb_i, noteOffStrb_i,
    output oscOut_o, voiceActive_o, activeOscPwm_o
  );
endinterface

// File: rtl/poly_voice_stack.sv
// Polyphonic voice allocator with per-voice square-wave oscillators and a
// PWM output whose duty tracks the fraction of busy voices.
module poly_voice_stack #(
  parameter int VOICES       = 4,
  parameter int STEAL_OLDEST = 1,
  parameter int DIV_BITS     = 22
) (
  input logic clk_i,
  input logic rst_i,
  poly_voice_stack_if.slave bus
);
  localparam int RW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int CW = $clog2(VOICES + 1);

  logic [VOICES-1:0]   active_q, active_d;
  logic [VOICES-1:0]   out_q, out_d;
  logic [6:0]          note_q [VOICES];
  logic [6:0]          note_d [VOICES];
  logic [RW-1:0]       rank_q [VOICES];
  logic [RW-1:0]       rank_d [VOICES];
  logic [DIV_BITS-1:0] hp_q   [VOICES];
  logic [DIV_BITS-1:0] hp_d   [VOICES];
  logic [DIV_BITS-1:0] cnt_q  [VOICES];
  logic [DIV_BITS-1:0] cnt_d  [VOICES];
  logic [RW-1:0]       p_q, p_d;
  logic                pwm_q, pwm_d;

  logic [3:0]          octave, semitone;
  logic [21:0]         base_hp;
  logic [DIV_BITS-1:0] hp_new;
  logic                hit, free_found, sel_valid, off_valid;
  logic [RW-1:0]       hit_idx, free_idx, steal_idx, sel_idx, prev_rank;
  logic [CW-1:0]       act_cnt;

  // Half period is resolved once at allocation so the per-voice datapath
  // only needs a counter compare, not a divider per voice.
  always_comb begin
    octave   = 4'(bus.note_i / 7'd12);
    semitone = 4'(bus.note_i % 7'd12);
    case (semitone)
      4'd0:    base_hp = 22'd3057805;
      4'd1:    base_hp = 22'd2886183;
      4'd2:    base_hp = 22'd2724196;
      4'd3:    base_hp = 22'd2571296;
      4'd4:    base_hp = 22'd2426980;
      4'd5:    base_hp = 22'd2290766;
      4'd6:    base_hp = 22'd2162196;
      4'd7:    base_hp = 22'd2040839;
      4'd8:    base_hp = 22'd1926293;
      4'd9:    base_hp = 22'd1818182;
      4'd10:   base_hp = 22'd1716135;
      4'd11:   base_hp = 22'd1619815;
      default: base_hp = 22'd0;
    endcase
    hp_new = DIV_BITS'(base_hp >> octave);
  end

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    steal_idx  = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (!hit && active_q[i] && note_q[i] == bus.note_i) begin
        hit     = 1'b1;
        hit_idx = RW'(i);
      end
      if (!free_found && !active_q[i]) begin
        free_found = 1'b1;
        free_idx   = RW'(i);
      end
      if (rank_q[i] == RW'(VOICES - 1)) steal_idx = RW'(i);
    end
    sel_valid = 1'b0;
    sel_idx   = '0;
    if (bus.noteOnStrb_i) begin
      if (hit) begin
        sel_valid = 1'b1;
        sel_idx   = hit_idx;
      end else if (free_found) begin
        sel_valid = 1'b1;
        sel_idx   = free_idx;
      end else if (STEAL_OLDEST != 0) begin
        sel_valid = 1'b1;
        sel_idx   = steal_idx;
      end
    end
    off_valid = !bus.noteOnStrb_i && bus.noteOffStrb_i && hit;
    prev_rank = rank_q[sel_idx];
  end

  always_comb begin
    active_d = active_q;
    out_d    = out_q;
    note_d   = note_q;
    rank_d   = rank_q;
    hp_d     = hp_q;
    cnt_d    = cnt_q;
    act_cnt  = '0;
    for (int i = 0; i < VOICES; i++) begin
      act_cnt = act_cnt + CW'(active_q[i]);
      if (sel_valid) begin
        if (RW'(i) == sel_idx) rank_d[i] = '0;
        else if (rank_q[i] < prev_rank) rank_d[i] = rank_q[i] + RW'(1);
      end
      if (sel_valid && RW'(i) == sel_idx) begin
        active_d[i] = 1'b1;
        note_d[i]   = bus.note_i;
        hp_d[i]     = hp_new;
        cnt_d[i]    = '0;
        out_d[i]    = 1'b0;
      end else if (off_valid && RW'(i) == hit_idx) begin
        active_d[i] = 1'b0;
        cnt_d[i]    = '0;
        out_d[i]    = 1'b0;
      end else if (active_q[i]) begin
        if (cnt_q[i] == hp_q[i] - DIV_BITS'(1)) begin
          cnt_d[i] = '0;
          out_d[i] = ~out_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_BITS'(1);
        end
      end else begin
        cnt_d[i] = '0;
        out_d[i] = 1'b0;
      end
    end
    p_d   = (p_q == RW'(VOICES - 1)) ? '0 : p_q + RW'(1);
    pwm_d = CW'(p_q) < act_cnt;
  end

  // Reset ranks make voice 0 the oldest, so fresh steals start at voice 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= '0;
      out_q    <= '0;
      p_q      <= '0;
      pwm_q    <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= '0;
        rank_q[i] <= RW'(VOICES - 1 - i);
        hp_q[i]   <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      active_q <= active_d;
      out_q    <= out_d;
      p_q      <= p_d;
      pwm_q    <= pwm_d;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= note_d[i];
        rank_q[i] <= rank_d[i];
        hp_q[i]   <= hp_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign bus.oscOut_o       = out_q;
  assign bus.voiceActive_o  = active_q;
  assign bus.activeOscPwm_o = pwm_q;
endmodule
